// File: rtl/inst_fetch_unit_pkg.sv
// rtl/inst_fetch_unit_pkg.sv - shared types and constants for the fetch unit
// Purpose: opcode constants (sourced from defines.v), default reset PC,
//          the buffered {pc, instr} entry type and a HALT decode helper.
// Ports:   none (package).
`include "defines.v"

package inst_fetch_unit_pkg;

  localparam logic [4:0]  OPCODE_HALT      = `OPCODE_HALT;
  localparam logic [4:0]  OPCODE_FENCE     = `OPCODE_FENCE;
  localparam logic [31:0] RESET_PC_DEFAULT = `RESET_PC_VAL;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic is_halt(input logic [4:0] opcode);
    return opcode == OPCODE_HALT;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - fetch unit bus: imem req/rsp, redirect, decode handoff
// Purpose: bundles every handshake signal of the fetch unit.
// Ports:   master = fetch unit side (drives requests, decode outputs, halted);
//          slave  = environment side (memory, execute redirect, decoder).
interface inst_fetch_unit_if;

  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;
  logic        halted;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output id_valid, id_instr, id_pc,
    input  id_ready,
    output halted
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  id_valid, id_instr, id_pc,
    output id_ready,
    input  halted
  );

endinterface

// File: rtl/defines.v
// rtl/defines.v - shared ISA opcode and reset-vector constants
`ifndef INST_FETCH_DEFINES_V
`define INST_FETCH_DEFINES_V

// Major opcode field, instr[6:2]
`define OPCODE_LOAD    5'h00
`define OPCODE_FENCE   5'h03
`define OPCODE_OP_IMM  5'h04
`define OPCODE_STORE   5'h08
`define OPCODE_OP      5'h0C
`define OPCODE_BRANCH  5'h18
`define OPCODE_JAL     5'h1B
`define OPCODE_HALT    5'h1F

// First fetch address after reset
`define RESET_PC_VAL   32'h0000_0000

`endif

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// rtl/inst_fetch_unit_fetch_fifo.sv - prefetch buffer of {pc, instr} entries
// Purpose: DEPTH-entry FIFO; head is read straight from storage so a push
//          shows up on o_head one cycle later. Flush overrides push and pop.
// Ports:   clk, rst (async, active-high); i_push/i_push_data; i_pop; i_flush;
//          o_full, o_empty, o_count (occupancy), o_head (oldest entry).
module inst_fetch_unit_fetch_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  fetch_entry_t  i_push_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count,
  output fetch_entry_t  o_head
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // When full, wr_ptr == rd_ptr: a simultaneous push overwrites the slot
      // that is being popped this same edge, which is exactly what we want.
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(i_push && !i_flush && !i_pop && o_full));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(i_pop && !i_flush && o_empty));

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - in-order instruction fetch front end
// Purpose: issues word fetches, tracks outstanding requests and stale
//          responses after a redirect, buffers words with their PCs for
//          decode and stops fetching once a HALT has been delivered.
// Ports:   clk, rst (async, active-high);
//          bus (master): imem_req_*/imem_rsp_* memory side, redirect_*
//          from execute, id_* decode handoff, halted status.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  inst_fetch_unit_if.master  bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;      // PC of the next non-stale response
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;    // responses still owed for pre-redirect requests
  logic          r_halted;

  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [CW-1:0] w_fifo_count;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_data;

  logic [CW:0]   w_inflight;
  logic          w_req_valid;
  logic          w_accept;
  logic          w_rsp;
  logic          w_pop;
  logic          w_halt_pop;
  logic          w_rsp_drop;
  logic          w_push;
  logic          w_flush;
  logic          w_redirect;
  logic [CW-1:0] w_out_nxt;

  assign w_redirect = bus.redirect_valid;
  assign w_inflight = {1'b0, r_outstanding} + {1'b0, w_fifo_count};

  // Every request reserves a buffer slot, so occupancy can never exceed DEPTH.
  assign w_req_valid = !rst && !r_halted && !w_redirect && !w_fifo_full
                     && (w_inflight < (CW+1)'(DEPTH));
  assign w_accept    = w_req_valid && bus.imem_req_ready;
  assign w_rsp       = bus.imem_rsp_valid;
  assign w_pop       = !w_fifo_empty && bus.id_ready;
  assign w_halt_pop  = w_pop && is_halt(w_head.instr[6:2]);

  // A HALT popped this cycle flushes the buffer, so a word arriving alongside
  // it is discarded as well.
  assign w_rsp_drop  = (r_drop_cnt != '0) || r_halted || w_halt_pop;
  assign w_push      = w_rsp && !w_rsp_drop && !w_redirect;
  assign w_flush     = w_redirect || w_halt_pop;
  assign w_out_nxt   = r_outstanding + CW'(w_accept) - CW'(w_rsp);

  assign w_push_data.pc    = r_rsp_pc;
  assign w_push_data.instr = bus.imem_rsp_data;

  inst_fetch_unit_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop && !w_flush),
    .i_flush     (w_flush),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count),
    .o_head      (w_head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_halted      <= 1'b0;
    end else begin
      r_outstanding <= w_out_nxt;
      if (w_redirect) begin
        r_fetch_pc <= bus.redirect_pc & ~32'h3;
        r_rsp_pc   <= bus.redirect_pc & ~32'h3;
        // Everything still in flight after this edge belongs to the old path.
        r_drop_cnt <= w_out_nxt;
        r_halted   <= 1'b0;
      end else begin
        if (w_accept) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_rsp) begin
          if (r_drop_cnt != '0) begin
            r_drop_cnt <= r_drop_cnt - CW'(1);
          end else begin
            r_rsp_pc <= r_rsp_pc + 32'd4;
          end
        end
        if (w_halt_pop) begin
          r_halted <= 1'b1;
        end
      end
    end
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.id_valid       = !w_fifo_empty;
  assign bus.id_instr       = w_head.instr;
  assign bus.id_pc          = w_head.pc;
  assign bus.halted         = r_halted;

  a_inflight_bound: assert property (@(posedge clk) disable iff (rst)
    w_inflight <= (CW+1)'(DEPTH));

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Front end of the processor. Produces the instruction stream that the control-unit decoder consumes.
- Issues in-order word reads to instruction memory through a valid/ready request and response interface, with variable memory latency.
- Buffers returned words with their PCs and hands them to decode over a valid/ready handshake.
- Handles branch/jump redirects from execute and stops fetching after a HALT instruction is delivered.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- DEPTH, 2, prefetch buffer entries. This is also the maximum number of outstanding requests. Must be a power of 2, at least 2.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous reset, active-high.
- imem_req_valid  out  1  a fetch request is presented.
- imem_req_addr  out  32  word-aligned fetch address; bits [1:0] are always 0.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_rsp_valid  in  1  response word is valid. Responses return in request order, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  single-cycle pulse: change fetch PC.
- redirect_pc  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- id_valid  out  1  id_instr/id_pc hold a valid instruction.
- id_instr  out  32  instruction to the decoder.
- id_pc  out  32  PC of id_instr.
- id_ready  in  1  decode accepts this cycle.
- halted  out  1  a HALT instruction has been delivered; fetch is stopped.

Behaviour:
- Reset (asynchronous, rst=1):
  - fetch_pc=RESET_PC; buffer empty; outstanding=0; drop_cnt=0; halted=0.
  - imem_req_valid=0, id_valid=0, id_instr=0, id_pc=0.
  - Asserting rst mid-transaction abandons in-flight responses. Memory is reset by the same rst, so no stale responses arrive.
- Request issue:
  - imem_req_valid=1 when !halted && (outstanding + occupancy) < DEPTH && !redirect_valid.
  - imem_req_addr=fetch_pc.
  - On accept (valid && ready): fetch_pc += 4 (32-bit wrap, 32'hFFFF_FFFC -> 0), outstanding+1.
  - A request held without ready keeps its address stable.
- Response:
  - Each imem_rsp_valid decrements outstanding.
  - If drop_cnt>0, the word is discarded and drop_cnt-1.
  - Otherwise the word is pushed with its PC. The PC comes from a per-request PC queue, or equivalently from a tracked next-response PC.
  - A simultaneous accept and response in the same cycle leaves outstanding unchanged.
- Decode output:
  - Buffer head drives id_valid/id_instr/id_pc.
  - Pop when id_valid && id_ready.
  - Push and pop in the same cycle is allowed, including when full.
  - Zero-bubble path: a response arriving to an empty buffer appears on id_* the next cycle (1-cycle registered latency).
- Redirect (redirect_valid=1):
  - Next cycle: buffer flushed, id_valid=0.
  - fetch_pc=redirect_pc & ~3; halted cleared.
  - drop_cnt = outstanding, adjusted for a response arriving in the same cycle.
  - No request is issued in the redirect cycle.
  - Redirect takes priority over push, pop, halt and request accept in the same cycle. A request accepted in that cycle counts toward drop_cnt.
- HALT:
  - When the delivered word (pop) has instr[6:2]==OPCODE_HALT, halted=1 from the next cycle.
  - Requests stop; further responses are dropped; remaining buffered words are flushed.
  - Exit only by redirect or rst.
- FENCE: passes through like any other instruction.
- Invariant: outstanding + occupancy <= DEPTH at all times.
- Overflow is impossible by construction. Any push attempt on a full buffer is an assertion failure.

Decomposition:
- OPCODE_* constants (OPCODE_HALT in particular) come from the shared defines.v include; no local copies.
- RESET_PC default value lives in defines.v as a named constant.
- One sub-module: fetch_fifo. It is DEPTH entries of {pc[31:0], instr[31:0]}, with push, pop, flush, full, empty and head outputs. Same-cycle push/pop is legal when full.
- Counters, drop logic and halt live in inst_fetch_unit.

Test Plan:
- Reset, then 0-latency memory with ready=1 and id_ready=1 → id_pc sequence 0x0, 0x4, 0x8…, one instruction per cycle after pipeline fill; halted=0.
- id_ready=0 for 10 cycles → at most DEPTH=2 requests accepted, then imem_req_valid=0. Releasing id_ready → delivery in order, with no loss or duplication.
- Memory latency 3 cycles, redirect to 0x103 while 2 requests are outstanding → both stale responses dropped; next id_pc=0x100.
- Word 0x0000007F-style HALT encoding (instr[6:2]=OPCODE_HALT) at PC 0x8 accepted → halted=1 the next cycle; imem_req_valid stays 0 for 20 cycles. Redirect to 0x40 → halted=0 and fetch resumes at 0x40.
- rst asserted asynchronously mid-stall with buffer full → outputs go to reset values immediately. After release, the first imem_req_addr=RESET_PC.
- fetch_pc starting at 0xFFFF_FFFC → next request address 0x0000_0000.
